// File: rtl/pmem_arbiter_pkg.sv
// Shared definitions for the physical-memory arbiter: FSM state and port-owner encodings.
package pmem_arb_defs;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  typedef enum logic {
    OWNER_IFU = 1'b0,
    OWNER_LSU = 1'b1
  } owner_e;

endpackage

// File: rtl/pmem_arbiter_timeout.sv
// Cycle counter guarding one outstanding memory transaction; expired_o flags the
// last allowed ISSUE/WAIT cycle.
module arb_timeout_cnt #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned      CW   = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]    LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Count starts at 0 in the first ISSUE cycle, so TIMEOUT-1 marks the TIMEOUT-th cycle.
  assign expired_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/pmem_arbiter.sv
// Two-port (IFU/LSU) arbiter for the single PMEM port: one outstanding transaction,
// fixed-priority or round-robin, with a timeout that forces an error completion.
module pmem_arbiter
  import pmem_arb_defs::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MASK_W   = 8,
  parameter int unsigned PRIO_LSU = 1,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_req,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_gnt,
  output logic              ifu_rvalid,
  output logic [DATA_W-1:0] ifu_rdata,
  output logic              ifu_err,
  input  logic              lsu_req,
  input  logic              lsu_we,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [MASK_W-1:0] lsu_wmask,
  output logic              lsu_gnt,
  output logic              lsu_rvalid,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              lsu_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [MASK_W-1:0] mem_wmask,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e state_q, state_d;
  owner_e owner_q;
  owner_e grant_owner;
  logic   grant;
  logic   complete;
  logic   expired;
  logic   timeout_hit;
  logic   finish;

  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [MASK_W-1:0] mem_wmask_q;

  logic              ifu_rvalid_q, ifu_err_q;
  logic              lsu_rvalid_q, lsu_err_q;
  logic [DATA_W-1:0] ifu_rdata_q, lsu_rdata_q;
  logic [DATA_W-1:0] resp_data;

  // owner_q doubles as last_owner: it is rewritten on every grant and holds in between.
  always_comb begin
    grant_owner = OWNER_IFU;
    if (ifu_req && lsu_req) begin
      grant_owner = ((PRIO_LSU != 0) || (owner_q == OWNER_IFU)) ? OWNER_LSU : OWNER_IFU;
    end else if (lsu_req) begin
      grant_owner = OWNER_LSU;
    end
  end

  // Gated by rst so grants vanish the moment reset is asserted.
  assign grant = rst && (state_q == ST_IDLE) && (ifu_req || lsu_req);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    complete = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        complete = mem_gnt && mem_rvalid;
        if (complete || expired) state_d = ST_IDLE;
        else if (mem_gnt)        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        complete = mem_rvalid;
        if (complete || expired) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_req = (state_q == ST_ISSUE);
    ifu_gnt = grant && (grant_owner == OWNER_IFU);
    lsu_gnt = grant && (grant_owner == OWNER_LSU);
  end

  assign timeout_hit = expired && !complete;
  assign finish      = complete || timeout_hit;
  assign resp_data   = (timeout_hit || mem_we_q) ? '0 : mem_rdata;

  arb_timeout_cnt #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .rst_n    (rst),
    .clear_i  (grant),
    .en_i     (state_q != ST_IDLE),
    .expired_o(expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q     <= OWNER_LSU;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
    end else if (grant) begin
      owner_q <= grant_owner;
      if (grant_owner == OWNER_LSU) begin
        mem_we_q    <= lsu_we;
        mem_addr_q  <= lsu_addr;
        mem_wdata_q <= lsu_wdata;
        mem_wmask_q <= lsu_wmask;
      end else begin
        mem_we_q    <= 1'b0;
        mem_addr_q  <= ifu_addr;
        mem_wdata_q <= '0;
        mem_wmask_q <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ifu_rvalid_q <= 1'b0;
      ifu_err_q    <= 1'b0;
      ifu_rdata_q  <= '0;
      lsu_rvalid_q <= 1'b0;
      lsu_err_q    <= 1'b0;
      lsu_rdata_q  <= '0;
    end else begin
      ifu_rvalid_q <= finish && (owner_q == OWNER_IFU);
      ifu_err_q    <= timeout_hit && (owner_q == OWNER_IFU);
      lsu_rvalid_q <= finish && (owner_q == OWNER_LSU);
      lsu_err_q    <= timeout_hit && (owner_q == OWNER_LSU);
      if (finish && (owner_q == OWNER_IFU)) ifu_rdata_q <= resp_data;
      if (finish && (owner_q == OWNER_LSU)) lsu_rdata_q <= resp_data;
    end
  end

  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_wmask  = mem_wmask_q;
  assign ifu_rvalid = ifu_rvalid_q;
  assign ifu_err    = ifu_err_q;
  assign ifu_rdata  = ifu_rdata_q;
  assign lsu_rvalid = lsu_rvalid_q;
  assign lsu_err    = lsu_err_q;
  assign lsu_rdata  = lsu_rdata_q;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench: a fixed-priority instance (p_*) and a round-robin instance (r_*)
// share all inputs; both use TIMEOUT=8.
module tb_pmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ifu_req = 1'b0;
  logic [31:0] ifu_addr = '0;
  logic        lsu_req = 1'b0;
  logic        lsu_we = 1'b0;
  logic [31:0] lsu_addr = '0;
  logic [31:0] lsu_wdata = '0;
  logic [7:0]  lsu_wmask = '0;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  logic        p_ifu_gnt, p_ifu_rvalid, p_ifu_err, p_lsu_gnt, p_lsu_rvalid, p_lsu_err;
  logic [31:0] p_ifu_rdata, p_lsu_rdata, p_mem_addr, p_mem_wdata;
  logic        p_mem_req, p_mem_we;
  logic [7:0]  p_mem_wmask;
  logic        r_ifu_gnt, r_ifu_rvalid, r_ifu_err, r_lsu_gnt, r_lsu_rvalid, r_lsu_err;
  logic [31:0] r_ifu_rdata, r_lsu_rdata, r_mem_addr, r_mem_wdata;
  logic        r_mem_req, r_mem_we;
  logic [7:0]  r_mem_wmask;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pmem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MASK_W(8), .PRIO_LSU(1), .TIMEOUT(8)
  ) dut_p (
    .clk(clk), .rst(rst),
    .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_gnt(p_ifu_gnt),
    .ifu_rvalid(p_ifu_rvalid), .ifu_rdata(p_ifu_rdata), .ifu_err(p_ifu_err),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_wmask(lsu_wmask), .lsu_gnt(p_lsu_gnt), .lsu_rvalid(p_lsu_rvalid),
    .lsu_rdata(p_lsu_rdata), .lsu_err(p_lsu_err),
    .mem_req(p_mem_req), .mem_we(p_mem_we), .mem_addr(p_mem_addr),
    .mem_wdata(p_mem_wdata), .mem_wmask(p_mem_wmask),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  pmem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MASK_W(8), .PRIO_LSU(0), .TIMEOUT(8)
  ) dut_r (
    .clk(clk), .rst(rst),
    .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_gnt(r_ifu_gnt),
    .ifu_rvalid(r_ifu_rvalid), .ifu_rdata(r_ifu_rdata), .ifu_err(r_ifu_err),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_wmask(lsu_wmask), .lsu_gnt(r_lsu_gnt), .lsu_rvalid(r_lsu_rvalid),
    .lsu_rdata(r_lsu_rdata), .lsu_err(r_lsu_err),
    .mem_req(r_mem_req), .mem_we(r_mem_we), .mem_addr(r_mem_addr),
    .mem_wdata(r_mem_wdata), .mem_wmask(r_mem_wmask),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    do_reset();
    #1;
    chk("reset_p_gnt_rvalid", {p_ifu_gnt, p_lsu_gnt, p_ifu_rvalid, p_lsu_rvalid, p_ifu_err, p_lsu_err}, 64'h0);
    chk("reset_p_mem", {p_mem_req, p_mem_we, p_mem_wmask}, 64'h0);
    chk("reset_p_addr_data", {p_mem_addr, p_mem_wdata}, 64'h0);
    chk("reset_p_rdata", {p_ifu_rdata, p_lsu_rdata}, 64'h0);

    // 1: single IFU read, zero-wait memory
    ifu_req = 1'b1; ifu_addr = 32'h8000_0000; #1;
    chk("t1_c0_gnt", {p_ifu_gnt, p_lsu_gnt}, 64'h2);
    cyc();
    ifu_req = 1'b0; mem_gnt = 1'b1; #1;
    chk("t1_c1_mem_req", p_mem_req, 64'h1);
    chk("t1_c1_mem_addr", p_mem_addr, 64'h8000_0000);
    chk("t1_c1_we_mask_gnt", {p_mem_we, p_mem_wmask, p_ifu_gnt}, 64'h0);
    cyc();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0413; #1;
    chk("t1_c2_idle_bus", {p_mem_req, p_ifu_rvalid}, 64'h0);
    cyc();
    mem_rvalid = 1'b0; #1;
    chk("t1_c3_rvalid_err", {p_ifu_rvalid, p_ifu_err}, 64'h2);
    chk("t1_c3_rdata", p_ifu_rdata, 64'h0000_0413);
    chk("t1_c3_lsu_silent", {p_lsu_gnt, p_lsu_rvalid, p_lsu_err}, 64'h0);
    cyc();
    chk("t1_c4_pulse_end", p_ifu_rvalid, 64'h0);
    chk("t1_c4_rdata_hold", p_ifu_rdata, 64'h0000_0413);

    // 2: simultaneous requests, LSU priority; IFU granted in LSU's rvalid cycle
    ifu_req = 1'b1; ifu_addr = 32'h8000_0040;
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h8000_2000; #1;
    chk("t2_c0_gnt", {p_ifu_gnt, p_lsu_gnt}, 64'h1);
    cyc();
    lsu_req = 1'b0; mem_gnt = 1'b1; #1;
    chk("t2_c1_mem_addr", p_mem_addr, 64'h8000_2000);
    chk("t2_c1_ifu_gnt", p_ifu_gnt, 64'h0);
    cyc();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222; #1;
    chk("t2_c2_mem_addr", p_mem_addr, 64'h8000_2000);
    chk("t2_c2_ifu_gnt", p_ifu_gnt, 64'h0);
    cyc();
    mem_rvalid = 1'b0; #1;
    chk("t2_c3_lsu_rvalid", p_lsu_rvalid, 64'h1);
    chk("t2_c3_lsu_rdata", p_lsu_rdata, 64'h1111_2222);
    chk("t2_c3_ifu_gnt", p_ifu_gnt, 64'h1);
    cyc();
    ifu_req = 1'b0; mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hAAAA_5555; #1;
    chk("t2_c4_mem_req", p_mem_req, 64'h1);
    chk("t2_c4_mem_addr", p_mem_addr, 64'h8000_0040);
    cyc();
    mem_gnt = 1'b0; mem_rvalid = 1'b0; #1;
    chk("t2_c5_ifu_rvalid", {p_ifu_rvalid, p_lsu_rvalid}, 64'h2);
    chk("t2_c5_ifu_rdata", p_ifu_rdata, 64'hAAAA_5555);

    // 5: memory accepts but never answers; TIMEOUT=8
    cyc();
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h8000_3000; #1;
    chk("t5_c0_gnt", p_lsu_gnt, 64'h1);
    for (int k = 1; k <= 8; k++) begin
      cyc();
      lsu_req = 1'b0; mem_gnt = (k == 1); #1;
      chk($sformatf("t5_c%0d_no_rvalid", k), p_lsu_rvalid, 64'h0);
    end
    cyc();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_BAD0; #1;
    chk("t5_c9_rvalid_err", {p_lsu_rvalid, p_lsu_err}, 64'h3);
    chk("t5_c9_rdata", p_lsu_rdata, 64'h0);
    cyc();
    mem_rvalid = 1'b0; #1;
    chk("t5_c10_late_dropped", {p_lsu_rvalid, p_lsu_err, p_ifu_rvalid}, 64'h0);
    chk("t5_c10_rdata_hold", p_lsu_rdata, 64'h0);

    // 4: store with mem_gnt delayed 3 cycles
    cyc();
    lsu_req = 1'b1; lsu_we = 1'b1; lsu_addr = 32'h8000_1000;
    lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 8'h0F; #1;
    chk("t4_c0_gnt", p_lsu_gnt, 64'h1);
    for (int k = 1; k <= 4; k++) begin
      cyc();
      lsu_req = 1'b0; lsu_wdata = '0; lsu_wmask = '0; lsu_addr = '0;
      mem_gnt = (k == 4); #1;
      chk($sformatf("t4_c%0d_mem_req", k), p_mem_req, 64'h1);
      chk($sformatf("t4_c%0d_addr_data", k), {p_mem_addr, p_mem_wdata}, 64'h8000_1000_DEAD_BEEF);
      chk($sformatf("t4_c%0d_we_mask", k), {p_mem_we, p_mem_wmask}, 64'h10F);
    end
    cyc();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678; #1;
    chk("t4_c5_mem_req", p_mem_req, 64'h0);
    cyc();
    mem_rvalid = 1'b0; #1;
    chk("t4_c6_rvalid_err", {p_lsu_rvalid, p_lsu_err}, 64'h2);
    chk("t4_c6_rdata", p_lsu_rdata, 64'h0);

    // 3: round-robin, both requesters held, memory answers in the ISSUE cycle
    do_reset();
    lsu_we = 1'b0; ifu_addr = 32'h0000_0100; lsu_addr = 32'h0000_0200;
    ifu_req = 1'b1; lsu_req = 1'b1; mem_gnt = 1'b1; mem_rvalid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("t3_c%0d_gnt", i), {r_ifu_gnt, r_lsu_gnt},
          (i % 4 == 0) ? 64'h2 : (i % 4 == 2) ? 64'h1 : 64'h0);
      if (i % 2 == 1)
        chk($sformatf("t3_c%0d_addr", i), r_mem_addr, (i % 4 == 1) ? 64'h100 : 64'h200);
      cyc();
    end

    // 6: reset asserted while in WAIT
    ifu_req = 1'b0; lsu_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    cyc();
    ifu_req = 1'b1; lsu_req = 1'b1; ifu_addr = 32'h8000_0080; #1;
    chk("t6_c0_gnt", {r_ifu_gnt, r_lsu_gnt}, 64'h2);
    cyc();
    ifu_req = 1'b0; mem_gnt = 1'b1; #1;
    chk("t6_c1_mem_req", r_mem_req, 64'h1);
    cyc();
    mem_gnt = 1'b0; #1;
    rst = 1'b0; #1;
    chk("t6_rst_r_outputs", {r_mem_req, r_ifu_gnt, r_lsu_gnt, r_ifu_rvalid, r_lsu_rvalid}, 64'h0);
    chk("t6_rst_r_addr", r_mem_addr, 64'h0);
    chk("t6_rst_p_outputs", {p_mem_req, p_ifu_gnt, p_lsu_gnt}, 64'h0);
    mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
    cyc();
    chk("t6_rst_no_rvalid", {r_ifu_rvalid, r_ifu_err}, 64'h0);
    mem_rvalid = 1'b0;
    rst = 1'b1; ifu_req = 1'b1; #1;
    chk("t6_rr_first_ifu", {r_ifu_gnt, r_lsu_gnt}, 64'h2);
    cyc();
    ifu_req = 1'b0; lsu_req = 1'b0; #1;
    chk("t6_abandoned_no_rvalid", {r_ifu_rvalid, r_ifu_rdata}, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
